calc_input_conditioner: RTL and testbench
=========================================

Name: calc_input_conditioner

Overview:
Front end for the calculator datapath. Turns the raw Enter/Clear push-buttons and the 12 operand/opcode switches into clean inputs for the calculator FSM:
- synchronizes every input to the clock;
- debounces both buttons;
- emits exactly one single-cycle pulse per physical press;
- captures a coherent switch snapshot on the same edge as each Enter pulse.

Sits between board pins and the calculator core.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced button level changes (1 ms at 50 MHz); legal range 2..65535.
CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1.
SW_W, 12, switch bus width ([7:0] operand, [11:8] opcode).
BTN_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed; 0 = active-high.

Ports:
clock  in  1  system clock, all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
btn_enter_raw  in  1  raw Enter button, asynchronous to clock.
btn_clear_raw  in  1  raw Clear button, asynchronous to clock.
sw_raw  in  SW_W  raw switch bank, asynchronous to clock.
enter_pulse  out  1  one-cycle pulse per debounced Enter press.
clear_pulse  out  1  one-cycle pulse per debounced Clear press.
sw_value  out  SW_W  switch snapshot taken on the same edge as enter_pulse.
enter_held  out  1  debounced Enter level, 1 = pressed.
clear_held  out  1  debounced Clear level, 1 = pressed.

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0;
  - synchronizer flops load the "released" level (1 if BTN_ACTIVE_LOW, else 0);
  - switch synchronizers load 0;
  - counters 0; both button FSMs in RELEASED.
- Synchronization: 2-flop synchronizer on each button and each switch bit. Polarity is normalized after the synchronizer, so internally 1 = pressed.
- Per-button FSM, identical for Enter and Clear, states RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK:
  - RELEASED: sync=1 → PRESS_CHECK with cnt=1.
  - PRESS_CHECK:
    - sync=0 → RELEASED, cnt=0 (glitch rejected);
    - sync=1 and cnt==DEBOUNCE_CYCLES-1 → PRESSED, assert pulse for this edge only;
    - otherwise cnt++.
  - PRESSED: sync=0 → RELEASE_CHECK with cnt=1.
  - RELEASE_CHECK:
    - sync=1 → PRESSED, cnt=0, no new pulse;
    - sync=0 and cnt==DEBOUNCE_CYCLES-1 → RELEASED;
    - otherwise cnt++.
  - *_held = 1 in PRESSED and RELEASE_CHECK, 0 otherwise.
- Latency: take a raw press first sampled at edge 1 and held steady. The synchronized level is seen by the FSM at edge 3, and the pulse is high for exactly the cycle following edge DEBOUNCE_CYCLES+2.
- One pulse per press: holding a button indefinitely gives no repeat pulse. A new pulse requires a full debounced release (DEBOUNCE_CYCLES stable released cycles), then a new debounced press.
- Switch capture:
  - sw_value loads the synchronized switch bus on the edge that raises enter_pulse, and holds between Enter pulses;
  - sw_value is valid in the same cycle enter_pulse is high;
  - switches are not debounced and must be static while Enter is pressed.
- Simultaneous events: if Enter and Clear would pulse on the same edge, clear_pulse asserts and enter_pulse is suppressed for that press. sw_value is not updated. The Enter FSM still moves to PRESSED, so that press is consumed.
- enter_pulse and clear_pulse are never high in the same cycle.
- Counter never wraps: it saturates by construction at DEBOUNCE_CYCLES-1.
- Reset mid-count or mid-press:
  - everything returns to RELEASED immediately and no pulse is emitted;
  - a button still held after reset release must be debounced from scratch and then pulses once.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1.
1. Clean press: btn_enter_raw 1→0 held 20 cycles, sw_raw=12'h305 → enter_pulse high for exactly 1 cycle, 6 edges after first low sample; sw_value=12'h305 that cycle; enter_held=1 until release is debounced.
2. Bounce rejection: Enter toggles low 2 cycles, high 1 cycle, low 2 cycles, then high → no enter_pulse, enter_held stays 0; then a steady 10-cycle low → exactly one pulse.
3. Hold and release bounce: hold Enter 100 cycles, release with a 1-cycle low glitch 2 cycles into the release → exactly 1 pulse total, enter_held falls only after 4 stable high cycles.
4. Simultaneous press: Enter and Clear go low on the same edge with sw_raw=12'hABC, prior sw_value=12'h001 → clear_pulse 1 cycle, enter_pulse never, sw_value stays 12'h001.
5. Reset mid-debounce: assert reset_n low with Enter in PRESS_CHECK, cnt=2 → all outputs 0 asynchronously; release reset with Enter still held → one pulse 6 edges after reset release.
6. Back-to-back presses: two presses separated by 5 released cycles → two enter_pulses with different sw_value snapshots (12'h011 then 12'h022).

Source files
------------

// File: rtl/calc_input_conditioner.sv
// calc_input_conditioner: synchronizes, debounces and one-shots the Enter/Clear buttons and snapshots the switch bank on Enter
// Ports:
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset, synchronous release
//   btn_enter_raw in   raw Enter button, asynchronous
//   btn_clear_raw in   raw Clear button, asynchronous
//   sw_raw        in   raw switch bank [7:0] operand, [11:8] opcode, asynchronous
//   enter_pulse   out  one-cycle pulse per debounced Enter press
//   clear_pulse   out  one-cycle pulse per debounced Clear press
//   sw_value      out  switch snapshot loaded on the edge that raises enter_pulse
//   enter_held    out  debounced Enter level, 1 = pressed
//   clear_held    out  debounced Clear level, 1 = pressed
module calc_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_level,
  output logic o_fire,
  output logic o_held
);
  typedef enum logic [1:0] {RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;
  assign w_at_last = r_cnt == LAST;
  // Combinational so the top can arbitrate Enter against Clear on the very edge the press is accepted.
  assign o_fire = (r_state == PRESS_CHECK) && i_level && w_at_last;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
      o_held  <= 1'b0;
    end else begin
      case (r_state)
        RELEASED: if (i_level) begin
          r_state <= PRESS_CHECK;
          r_cnt   <= CNT_W'(1);
        end
        PRESS_CHECK: if (!i_level) begin
          r_state <= RELEASED;
          r_cnt   <= '0;
        end else if (w_at_last) begin
          r_state <= PRESSED;
          r_cnt   <= '0;
          o_held  <= 1'b1;
        end else r_cnt <= r_cnt + CNT_W'(1);
        PRESSED: if (!i_level) begin
          r_state <= RELEASE_CHECK;
          r_cnt   <= CNT_W'(1);
        end
        RELEASE_CHECK: if (i_level) begin
          r_state <= PRESSED;
          r_cnt   <= '0;
        end else if (w_at_last) begin
          r_state <= RELEASED;
          r_cnt   <= '0;
          o_held  <= 1'b0;
        end else r_cnt <= r_cnt + CNT_W'(1);
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
          o_held  <= 1'b0;
        end
      endcase
    end
  end
endmodule

module calc_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16,
  parameter int SW_W = 12,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            btn_enter_raw,
  input  logic            btn_clear_raw,
  input  logic [SW_W-1:0] sw_raw,
  output logic            enter_pulse,
  output logic            clear_pulse,
  output logic [SW_W-1:0] sw_value,
  output logic            enter_held,
  output logic            clear_held
);
  localparam logic REL = logic'(BTN_ACTIVE_LOW != 0);
  logic [1:0]      r_enter_sync, r_clear_sync;
  logic [SW_W-1:0] r_sw_meta, r_sw_sync;
  logic            w_enter_lvl, w_clear_lvl, w_enter_fire, w_clear_fire, w_enter_win;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_enter_sync <= {2{REL}};
      r_clear_sync <= {2{REL}};
      r_sw_meta    <= '0;
      r_sw_sync    <= '0;
    end else begin
      r_enter_sync <= {r_enter_sync[0], btn_enter_raw};
      r_clear_sync <= {r_clear_sync[0], btn_clear_raw};
      r_sw_meta    <= sw_raw;
      r_sw_sync    <= r_sw_meta;
    end
  end
  // XOR with the released level maps both polarities to 1 = pressed.
  assign w_enter_lvl = r_enter_sync[1] ^ REL;
  assign w_clear_lvl = r_clear_sync[1] ^ REL;
  calc_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
    .clock(clock), .reset_n(reset_n), .i_level(w_enter_lvl), .o_fire(w_enter_fire), .o_held(enter_held)
  );
  calc_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
    .clock(clock), .reset_n(reset_n), .i_level(w_clear_lvl), .o_fire(w_clear_fire), .o_held(clear_held)
  );
  // Clear wins a tie; the Enter FSM still advances, so the suppressed press is consumed.
  assign w_enter_win = w_enter_fire & ~w_clear_fire;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enter_pulse <= 1'b0;
      clear_pulse <= 1'b0;
      sw_value    <= '0;
    end else begin
      enter_pulse <= w_enter_win;
      clear_pulse <= w_clear_fire;
      if (w_enter_win) sw_value <= r_sw_sync;
    end
  end
endmodule

// File: tb/tb_calc_input_conditioner.sv
// tb_calc_input_conditioner: randomized and directed check of calc_input_conditioner against a run-length reference model
module tb_calc_input_conditioner;
  localparam int D = 4;
  logic        clock, reset_n, btn_enter_raw, btn_clear_raw;
  logic [11:0] sw_raw, sw_value;
  logic        enter_pulse, clear_pulse, enter_held, clear_held;
  int          n_checks, n_fails, step_idx, n_enter, n_clear, last_enter_step;
  logic        m_s1[2], m_s2[2], m_lvl[2];
  int          m_run[2];
  logic [11:0] m_sw1, m_sw2, exp_sw;
  logic        exp_enter, exp_clear;
  calc_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(16), .SW_W(12), .BTN_ACTIVE_LOW(1)) dut (
    .clock(clock), .reset_n(reset_n), .btn_enter_raw(btn_enter_raw), .btn_clear_raw(btn_clear_raw),
    .sw_raw(sw_raw), .enter_pulse(enter_pulse), .clear_pulse(clear_pulse), .sw_value(sw_value),
    .enter_held(enter_held), .clear_held(clear_held)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, step_idx);
    end
  endtask
  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_lvl[b] = 1'b0; m_run[b] = 0;
    end
    m_sw1 = '0; m_sw2 = '0; exp_sw = '0; exp_enter = 1'b0; exp_clear = 1'b0;
  endtask
  task automatic model_edge(input logic pe, input logic pc, input logic [11:0] sw);
    logic fire[2];
    logic in_lvl[2];
    logic samp;
    in_lvl[0] = pe; in_lvl[1] = pc;
    for (int b = 0; b < 2; b++) begin
      samp = m_s2[b]; m_s2[b] = m_s1[b]; m_s1[b] = in_lvl[b]; fire[b] = 1'b0;
      if (samp != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_lvl[b] = samp; m_run[b] = 0; fire[b] = samp;
        end
      end else m_run[b] = 0;
    end
    exp_clear = fire[1];
    exp_enter = fire[0] && !fire[1];
    if (exp_enter) exp_sw = m_sw2;
    m_sw2 = m_sw1; m_sw1 = sw;
  endtask
  task automatic compare_all(input string tag);
    check({tag, ".enter_pulse"}, 32'(enter_pulse), 32'(exp_enter));
    check({tag, ".clear_pulse"}, 32'(clear_pulse), 32'(exp_clear));
    check({tag, ".sw_value"}, 32'(sw_value), 32'(exp_sw));
    check({tag, ".enter_held"}, 32'(enter_held), 32'(m_lvl[0]));
    check({tag, ".clear_held"}, 32'(clear_held), 32'(m_lvl[1]));
    check({tag, ".exclusive"}, 32'(enter_pulse & clear_pulse), 32'd0);
  endtask
  task automatic step(input logic e, input logic c, input logic [11:0] sw);
    btn_enter_raw = e; btn_clear_raw = c; sw_raw = sw;
    @(posedge clock);
    model_edge(~e, ~c, sw);
    @(negedge clock);
    step_idx++;
    if (enter_pulse === 1'b1) begin n_enter++; last_enter_step = step_idx; end
    if (clear_pulse === 1'b1) n_clear++;
    compare_all("run");
  endtask
  task automatic steps(input int n, input logic e, input logic c, input logic [11:0] sw);
    for (int i = 0; i < n; i++) step(e, c, sw);
  endtask
  task automatic new_scenario();
    step_idx = 0; n_enter = 0; n_clear = 0; last_enter_step = -1;
  endtask
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    compare_all("async_reset");
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask
  initial begin
    n_checks = 0; n_fails = 0;
    btn_enter_raw = 1'b1; btn_clear_raw = 1'b1; sw_raw = '0; reset_n = 1'b0;
    model_reset();
    new_scenario();
    #1 compare_all("reset");
    @(negedge clock);
    @(negedge clock);
    compare_all("reset_hold");
    reset_n = 1'b1;
    steps(6, 1, 1, 12'h000);
    new_scenario();
    steps(20, 0, 1, 12'h305);
    check("clean.count", n_enter, 1);
    check("clean.latency", last_enter_step, 6);
    check("clean.sw", 32'(sw_value), 32'h305);
    check("clean.held", 32'(enter_held), 1);
    steps(10, 1, 1, 12'h305);
    check("clean.released", 32'(enter_held), 0);
    new_scenario();
    steps(2, 0, 1, 12'h000); steps(1, 1, 1, 12'h000); steps(2, 0, 1, 12'h000); steps(10, 1, 1, 12'h000);
    check("bounce.none", n_enter, 0);
    steps(10, 0, 1, 12'h000);
    check("bounce.one", n_enter, 1);
    steps(10, 1, 1, 12'h000);
    new_scenario();
    steps(100, 0, 1, 12'h0F0);
    steps(2, 1, 1, 12'h0F0); steps(1, 0, 1, 12'h0F0);
    steps(4, 1, 1, 12'h0F0);
    check("hold.still_held", 32'(enter_held), 1);
    steps(2, 1, 1, 12'h0F0);
    check("hold.released", 32'(enter_held), 0);
    check("hold.count", n_enter, 1);
    steps(4, 1, 1, 12'h0F0);
    steps(10, 0, 1, 12'h001); steps(10, 1, 1, 12'h001);
    check("simul.prior_sw", 32'(sw_value), 32'h001);
    new_scenario();
    steps(10, 0, 0, 12'hABC);
    check("simul.enter", n_enter, 0);
    check("simul.clear", n_clear, 1);
    check("simul.sw", 32'(sw_value), 32'h001);
    steps(10, 1, 1, 12'hABC);
    steps(4, 0, 1, 12'h055);
    do_reset();
    new_scenario();
    steps(10, 0, 1, 12'h055);
    check("rst.count", n_enter, 1);
    check("rst.latency", last_enter_step, 6);
    steps(10, 1, 1, 12'h055);
    new_scenario();
    steps(8, 0, 1, 12'h011);
    check("b2b.sw1", 32'(sw_value), 32'h011);
    steps(8, 1, 1, 12'h011);
    steps(8, 0, 1, 12'h022);
    check("b2b.sw2", 32'(sw_value), 32'h022);
    check("b2b.count", n_enter, 2);
    steps(8, 1, 1, 12'h022);
    for (int s = 0; s < 500; s++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      steps($urandom_range(1, 9), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 12'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
